// File: rtl/mult_share_arb.sv
// Round-robin arbiter sharing one 8x8 unsigned multiplier among NREQ requesters.
// Two-stage pipeline: operand register feeding the multiplier, then a product register.

module wallace (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);
  logic [15:0] pp [8];
  logic [15:0] s1, c1, s2, c2, s3, c3, s4, c4, s5, c5, s6, c6;

  // One 3:2 compressor row; the carry vector is pre-shifted into place.
  function automatic logic [31:0] csa(input logic [15:0] x, input logic [15:0] y,
                                      input logic [15:0] z);
    logic [15:0] s;
    logic [15:0] c;
    s = x ^ y ^ z;
    c = ((x & y) | (x & z) | (y & z)) << 1;
    return {c, s};
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_pp
      assign pp[gi] = {8'd0, a & {8{b[gi]}}} << gi;
    end
  endgenerate

  // 8 rows -> 6 -> 4 -> 3 -> 2, then one carry-propagate add.
  assign {c1, s1} = csa(pp[0], pp[1], pp[2]);
  assign {c2, s2} = csa(pp[3], pp[4], pp[5]);
  assign {c3, s3} = csa(s1, c1, s2);
  assign {c4, s4} = csa(c2, pp[6], pp[7]);
  assign {c5, s5} = csa(s3, c3, s4);
  assign {c6, s6} = csa(s5, c5, c4);
  assign p = s6 + c6;
endmodule

module mult_share_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [8*NREQ-1:0]    req_a,
  input  logic [8*NREQ-1:0]    req_b,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [15:0]          resp_data,
  output logic [IDW-1:0]       resp_id,
  output logic [15:0]          op_count
);
  logic [7:0]      a_arr [NREQ];
  logic [7:0]      b_arr [NREQ];
  logic [7:0]      s0_a, s0_b;
  logic [IDW-1:0]  s0_id;
  logic            s0_valid;
  logic [IDW-1:0]  rr_ptr, gnt_id, ptr_next, idx;
  logic [NREQ-1:0] grant;
  logic            gnt_any, s0_en, s1_en;
  logic [15:0]     prod;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign a_arr[gi] = req_a[8*gi +: 8];
      assign b_arr[gi] = req_b[8*gi +: 8];
    end
  endgenerate

  assign s1_en = !resp_valid | resp_ready;
  assign s0_en = !s0_valid | s1_en;

  // First valid requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    grant   = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(rr_ptr) + k) % NREQ);
      if (!gnt_any && req_valid[idx]) begin
        gnt_any     = 1'b1;
        gnt_id      = idx;
        grant[idx]  = 1'b1;
      end
    end
  end

  assign req_ready = rst ? '0 : (grant & {NREQ{s0_en}});
  assign ptr_next  = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;

  wallace u_mul (
    .a (s0_a),
    .b (s0_b),
    .p (prod)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid   <= 1'b0;
      s0_a       <= '0;
      s0_b       <= '0;
      s0_id      <= '0;
      rr_ptr     <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= '0;
      op_count   <= '0;
    end else begin
      if (s1_en) begin
        resp_valid <= s0_valid;
        resp_data  <= prod;
        resp_id    <= s0_id;
      end
      if (s0_en) begin
        if (gnt_any) begin
          s0_valid <= 1'b1;
          s0_a     <= a_arr[gnt_id];
          s0_b     <= b_arr[gnt_id];
          s0_id    <= gnt_id;
          rr_ptr   <= ptr_next;
        end else begin
          s0_valid <= 1'b0;
        end
      end
      if (resp_valid && resp_ready)
        op_count <= op_count + 16'd1;
    end
  end
endmodule

// File: doc/mult_share_arb.md
# mult_share_arb

Round-robin arbiter and pipeline controller that shares one `wallace` 8x8 unsigned multiplier among `NREQ` requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester per cycle, registers the operands into the multiplier, and registers the 16-bit product. It returns the product tagged with the requester index over a single response channel that supports backpressure. It sits between the algorithm engines and the single multiplier instance, and it is the only block that drives that multiplier's inputs.

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `IDW`, 2, index width; must equal clog2(`NREQ`)
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  NREQ  per-requester request valid
- `req_ready`  out  NREQ  per-requester accept; at most one bit high
- `req_a`  in  8*NREQ  operand A; requester i uses bits [8i+7:8i]
- `req_b`  in  8*NREQ  operand B; same packing
- `resp_valid`  out  1  product register holds a result
- `resp_ready`  in  1  consumer accepts the result
- `resp_data`  out  16  unsigned product a*b
- `resp_id`  out  IDW  index of the originating requester
- `op_count`  out  16  number of completed responses (valid & ready); wraps at 65535 to 0

## Operation
- **Multiplier:** one `wallace` instance, fed only from the operand register (`s0_a`, `s0_b`). The product is an exact unsigned 16-bit value (max 255*255 = 65025); no truncation.
- **Pipeline:**
  - Stage 0 holds the operand register plus `s0_id` and `s0_valid`.
  - Stage 1 holds the result register (`resp_data`, `resp_id`, `resp_valid`).
- **Advance conditions:**
  - `s1_en = !resp_valid | resp_ready`.
  - `s0_en = !s0_valid | s1_en`.
  - When `s1_en`: stage 1 loads the `wallace` result and `s0_id`, and `resp_valid <= s0_valid`.
- **Arbitration:** combinational round-robin from pointer `rr_ptr`.
  - Grant goes to the first i with `req_valid[i]` high, scanning `rr_ptr`, `rr_ptr`+1, ... mod NREQ.
  - `req_ready[i] = grant[i] & s0_en`.
  - `req_ready` may depend on `req_valid`. Requesters hold `req_valid`/`req_a`/`req_b` stable until accepted.
- **Accept:** `req_valid[i] & req_ready[i]` at an edge.
  - Stage 0 loads that requester's a, b and i; `s0_valid <= 1`.
  - `rr_ptr <= (i+1) mod NREQ`.
- **Stage 0 empties:** when `s0_en` is true but no request is granted, `s0_valid <= 0` and `rr_ptr` is unchanged.
- **Ordering:** responses leave in acceptance order; no reordering and no drops.
- **Counting:** `op_count` increments on each edge with `resp_valid & resp_ready`.
- **Reset (rst high at an edge):**
  - `s0_valid`, `resp_valid`, `rr_ptr`, `resp_data`, `resp_id`, `op_count` all go to 0.
  - `req_ready` is all 0 while `rst` is high.
  - In-flight operations are discarded and produce no response.

## Timing
- **Latency:** a request accepted at edge T has `resp_valid` high after edge T+1, provided `resp_ready` was high or stage 1 was empty at T+1.
- **Throughput:** 1 accept per cycle with `resp_ready` held high.
- **Capacity:** at most 2 operations in flight (stage 0 + stage 1).
- **Backpressure:** with `resp_valid` high and `resp_ready` low:
  - stage 1 holds;
  - stage 0 holds if full;
  - once both are full, all `req_ready` are low.
- **Simultaneous accept and drain at edge T:** stage 1 takes stage 0's product, and stage 0 takes the new request in the same edge.
- **Pointer rules:** the pointer advances only on accept. A lone requester is granted every cycle regardless of `rr_ptr`.
- **Outputs:** all outputs except `req_ready` are registered.

## Test plan
- **Single op:** after reset, requester 2 sends a=12, b=13 at edge T. Required: `resp_valid` high after T+1, `resp_data`=156, `resp_id`=2, `op_count`=1 after the response handshake.
- **Extremes:** requester 0 sends 255*255 and then 0*200. Required: `resp_data` 65025 then 0, back-to-back, with `resp_ready` held high.
- **Fairness:** all 4 `req_valid` held high continuously, each with a distinct operand pair. Required: accept order 0,1,2,3,0,1,... one per cycle; every response carries the matching id and product.
- **Backpressure:** requesters 1 and 3 continuously valid, `resp_ready` low for 5 cycles starting after the first response. Required:
  - exactly 2 ops are held;
  - all `req_ready` are low after the pipeline fills;
  - `resp_data`/`resp_id` are stable while stalled;
  - on release, responses resume in order with no loss or duplication.
- **Reset mid-operation:** `rst` asserted one cycle after accepting 7*9 (pipeline full). Required after that edge:
  - `resp_valid`=0, `op_count`=0, `rr_ptr`=0;
  - no response for 63 ever appears;
  - the next request after `rst` falls completes normally.
- **Counter wrap:** preload by running 65536 responses. Required: `op_count` reads 0 after the 65536th handshake.
